// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle integer ops plus iterative
// shift-add multiply and restoring divide, both one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_XOR   = 5'h04;
  localparam logic [4:0] OP_NOR   = 5'h05;
  localparam logic [4:0] OP_SLL   = 5'h06;
  localparam logic [4:0] OP_SRL   = 5'h07;
  localparam logic [4:0] OP_SRA   = 5'h08;
  localparam logic [4:0] OP_SLT   = 5'h09;
  localparam logic [4:0] OP_PASSA = 5'h0A;
  localparam logic [4:0] OP_PASSB = 5'h0B;
  localparam logic [4:0] OP_BP8   = 5'h0C;
  localparam logic [4:0] OP_SLTU  = 5'h0D;

  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             is_div, qneg, rneg, dz_q, v_q;
  logic [WIDTH-1:0] a_q, d_q, w_hi, w_lo;

  logic [WIDTH-1:0] s_res, sum, diff;
  logic [SHW-1:0]   sh;
  logic             s_flag, s_z, s_n, s_v;

  always_comb begin
    sh     = a[SHW-1:0];
    sum    = a + b;
    diff   = a - b;
    s_res  = '0;
    s_v    = 1'b0;
    s_flag = 1'b0;
    case (op)
      OP_ADD: begin
        s_res  = sum;
        s_v    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        s_flag = 1'b1;
      end
      OP_SUB: begin
        s_res  = diff;
        s_v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        s_flag = 1'b1;
      end
      OP_AND:   s_res = a & b;
      OP_OR:    s_res = a | b;
      OP_XOR:   s_res = a ^ b;
      OP_NOR:   s_res = ~(a | b);
      OP_SLL:   s_res = b << sh;
      OP_SRL:   s_res = b >> sh;
      OP_SRA:   s_res = $signed(b) >>> sh;
      OP_SLT: begin
        s_res  = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        s_flag = 1'b1;
      end
      OP_PASSA: begin
        s_res  = a;
        s_flag = 1'b1;
      end
      OP_PASSB: begin
        s_res  = b;
        s_flag = 1'b1;
      end
      OP_BP8:   s_res = b + WIDTH'(8);
      OP_SLTU: begin
        s_res  = {{(WIDTH-1){1'b0}}, (a < b)};
        s_flag = 1'b1;
      end
      default: ;
    endcase
    s_z = s_flag && (s_res == '0);
    s_n = s_flag && s_res[WIDTH-1];
  end

  // Operand conditioning at accept: iterate on magnitudes, fix signs at the end
  logic             is_iter, op_div, op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_iter = (op[4:2] == 3'b100);
    op_div  = op[1];
    op_sgn  = ~op[0];
    a_neg   = op_sgn & a[WIDTH-1];
    b_neg   = op_sgn & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
  end

  logic [WIDTH:0]   madd, dt;
  logic [WIDTH-1:0] dsub, m_hi, m_lo, d_hi, d_lo, n_hi, n_lo;
  logic             dge;

  always_comb begin
    madd = {1'b0, w_hi} + {1'b0, d_q};
    m_hi = w_lo[0] ? madd[WIDTH:1] : {1'b0, w_hi[WIDTH-1:1]};
    m_lo = w_lo[0] ? {madd[0], w_lo[WIDTH-1:1]} : {w_hi[0], w_lo[WIDTH-1:1]};
    dt   = {w_hi, w_lo[WIDTH-1]};
    dge  = (dt >= {1'b0, d_q});
    dsub = dt[WIDTH-1:0] - d_q;
    d_hi = dge ? dsub : dt[WIDTH-1:0];
    d_lo = {w_lo[WIDTH-2:0], dge};
    n_hi = is_div ? d_hi : m_hi;
    n_lo = is_div ? d_lo : m_lo;
  end

  // Final result is formed from the last step's values so it lands with that step
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, f_res, f_hi;
  logic               f_z, f_n;

  always_comb begin
    prod = {n_hi, n_lo};
    if (qneg) prod = -prod;
    quo = qneg ? -n_lo : n_lo;
    rem = rneg ? -n_hi : n_hi;
    if (dz_q) begin
      quo = '1;
      rem = a_q;
    end else if (v_q) begin
      quo = MIN_NEG;
      rem = '0;
    end
    if (is_div) begin
      f_res = quo;
      f_hi  = rem;
      f_z   = (quo == '0);
      f_n   = quo[WIDTH-1];
    end else begin
      f_res = prod[WIDTH-1:0];
      f_hi  = prod[2*WIDTH-1:WIDTH];
      f_z   = (prod == '0);
      f_n   = prod[2*WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      is_div    <= 1'b0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      dz_q      <= 1'b0;
      v_q       <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      w_hi      <= '0;
      w_lo      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (is_iter) begin
              state  <= CALC;
              cnt    <= '0;
              is_div <= op_div;
              qneg   <= a_neg ^ b_neg;
              rneg   <= a_neg;
              dz_q   <= op_div && (b == '0);
              v_q    <= op_div && op_sgn && (a == MIN_NEG) && (b == '1);
              a_q    <= a;
              w_hi   <= '0;
              w_lo   <= op_div ? a_mag : b_mag;
              d_q    <= op_div ? b_mag : a_mag;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= s_res;
              hi        <= '0;
              z         <= s_z;
              n         <= s_n;
              v         <= s_v;
              dz        <= 1'b0;
            end
          end
        end
        CALC: begin
          w_hi <= n_hi;
          w_lo <= n_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
            result    <= f_res;
            hi        <= f_hi;
            z         <= f_z;
            n         <= f_n;
            v         <= is_div & v_q;
            dz        <= is_div & dz_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit instance for the main vectors and
// an 8-bit instance for the narrow multiply case.
module tb_alu_seq;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result, hi;
  logic        z, n, v, dz;

  logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, result8, hi8;
  logic        z8, n8, v8, dz8;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ov32_d = 1'b0;
  logic ov8_d = 1'b0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi),
    .z(z), .n(n), .v(v), .dz(dz)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8),
    .in_ready(in_ready8), .op(op8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .hi(hi8),
    .z(z8), .n(n8), .v(v8), .dz(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic compareEntry(input exp_t e, input logic [31:0] r, input logic [31:0] h,
                              input logic [3:0] f, input int cy);
    checkOutput({e.name, ".result"}, r, e.res);
    checkOutput({e.name, ".hi"}, h, e.hi);
    checkOutput({e.name, ".flags_znvd"}, {28'd0, f}, {28'd0, e.flg});
    checkOutput({e.name, ".latency"}, 32'(cy - e.acc), 32'(e.lat));
  endtask

  // Scoreboard monitors: pop one expectation on each rising out_valid
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov32_d) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out32: out_valid=1 with nothing pending, result=%h", result);
      end else begin
        e32 = q32.pop_front();
        compareEntry(e32, result, hi, {z, n, v, dz}, cyc);
      end
    end
    ov32_d = out_valid;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && !ov8_d) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out8: out_valid=1 with nothing pending, result=%h", result8);
      end else begin
        e8 = q8.pop_front();
        compareEntry(e8, {24'd0, result8}, {24'd0, hi8}, {z8, n8, v8, dz8}, cyc);
      end
    end
    ov8_d = out_valid8;
  end

  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit track, input string nm, input logic [31:0] er,
                               input logic [31:0] eh, input logic [3:0] ef, input int lat);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.in_ready_timeout: got in_ready=0, expected 1 within 200 cycles", nm);
      return;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    if (track) q32.push_back('{nm, er, eh, ef, lat, cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string nm, input logic [31:0] er, input logic [31:0] eh,
                       input logic [3:0] ef, input int lat);
    applyStimulus(o, x, y, 1'b1, nm, er, eh, ef, lat);
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d results outstanding, expected 0",
               q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  task automatic checkIdleZero(input string nm);
    checkOutput({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({nm, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({nm, ".result"}, result, 32'd0);
    checkOutput({nm, ".hi"}, hi, 32'd0);
    checkOutput({nm, ".flags_znvd"}, {28'd0, z, n, v, dz}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach its end within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int t;
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    checkOutput("reset8.in_ready", {31'd0, in_ready8}, 32'd1);
    rst_n = 1'b1;

    // Single-cycle ops
    issue(5'h00, 32'h7FFFFFFF, 32'h00000001, "add_ovf",   32'h80000000, 0, 4'b0110, 1);
    issue(5'h01, 32'd5,        32'd5,        "sub_zero",  32'h00000000, 0, 4'b1000, 1);
    issue(5'h01, 32'h80000000, 32'd1,        "sub_ovf",   32'h7FFFFFFF, 0, 4'b0010, 1);
    issue(5'h02, 32'hF0F0F0F0, 32'hFF00FF00, "and",       32'hF000F000, 0, 4'b0000, 1);
    issue(5'h05, 32'd0,        32'd0,        "nor",       32'hFFFFFFFF, 0, 4'b0000, 1);
    issue(5'h06, 32'h0000001F, 32'd1,        "sll",       32'h80000000, 0, 4'b0000, 1);
    issue(5'h07, 32'h00000021, 32'h80000000, "srl",       32'h40000000, 0, 4'b0000, 1);
    issue(5'h09, 32'hFFFFFFFF, 32'd1,        "slt",       32'h00000001, 0, 4'b0000, 1);
    issue(5'h0D, 32'hFFFFFFFF, 32'd1,        "sltu",      32'h00000000, 0, 4'b1000, 1);
    issue(5'h0A, 32'h80000001, 32'd7,        "passa",     32'h80000001, 0, 4'b0100, 1);
    issue(5'h0B, 32'd5,        32'd0,        "passb",     32'h00000000, 0, 4'b1000, 1);
    issue(5'h0C, 32'd3,        32'hFFFFFFF8, "bplus8",    32'h00000000, 0, 4'b0000, 1);
    issue(5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, "illegal",   32'h00000000, 0, 4'b0000, 1);

    // Signed multiply; in_ready must stay low while it iterates
    issue(5'h10, 32'hFFFFFFFD, 32'd7, "mul_neg", 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0100, 33);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready || out_valid) bad++;
      @(negedge clk);
    end
    checkOutput("mul_neg.busy_cycles_bad", 32'(bad), 32'd0);
    waitDrain();

    // Reset in the middle of a divide
    applyStimulus(5'h13, 32'd100, 32'd3, 1'b0, "divu_abort", 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleZero("reset_mid_divu");
    @(negedge clk);
    rst_n = 1'b1;

    issue(5'h12, 32'hFFFFFFF9, 32'd2,        "div_neg",   32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0100, 33);
    issue(5'h12, 32'd7,        32'hFFFFFFFE, "div_negb",  32'hFFFFFFFD, 32'h00000001, 4'b0100, 33);
    issue(5'h13, 32'd7,        32'd0,        "divu_dz",   32'hFFFFFFFF, 32'h00000007, 4'b0101, 33);
    issue(5'h12, 32'hFFFFFFF8, 32'd0,        "div_dz",    32'hFFFFFFFF, 32'hFFFFFFF8, 4'b0101, 33);
    issue(5'h12, 32'h80000000, 32'hFFFFFFFF, "div_ovf",   32'h80000000, 32'h00000000, 4'b0110, 33);
    issue(5'h13, 32'd100,      32'd7,        "divu",      32'h0000000E, 32'h00000002, 4'b0000, 33);
    issue(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu_max",  32'h00000001, 32'hFFFFFFFE, 4'b0100, 33);
    issue(5'h10, 32'd0,        32'hFFFFFFFB, "mul_zero",  32'h00000000, 32'h00000000, 4'b1000, 33);
    issue(5'h10, 32'h80000000, 32'h80000000, "mul_min",   32'h00000000, 32'h40000000, 4'b0000, 33);
    waitDrain();

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(5'h08, 32'h00000024, 32'h80000000, "sra_hold", 32'hF8000000, 0, 4'b0000, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (result !== 32'hF8000000 || !out_valid || in_ready || z || n) bad++;
      @(negedge clk);
    end
    checkOutput("hold.bad_cycles", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold.release_out_valid", {31'd0, out_valid}, 32'd0);
    waitDrain();

    // Flush in the middle of a multiply
    applyStimulus(5'h11, 32'd3, 32'd5, 1'b0, "mulu_flush", 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush.out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("flush.out_valid_later", {31'd0, out_valid}, 32'd0);

    // Flush wins over a simultaneous accept
    op = 5'h00; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_accept.in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("flush_accept.out_valid", {31'd0, out_valid}, 32'd0);
    issue(5'h04, 32'h0000FFFF, 32'h00FF00FF, "xor_after_flush", 32'h00FFFF00, 0, 4'b0000, 1);
    waitDrain();

    // Narrow instance: 255*255 unsigned
    t = 0;
    while (!in_ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("mulu8.in_ready", {31'd0, in_ready8}, 32'd1);
    op8 = 5'h11; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    q8.push_back('{"mulu8", 32'h01, 32'hFE, 4'b0100, 9, cyc});
    @(negedge clk);
    in_valid8 = 1'b0;
    waitDrain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
